// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external word bus between instruction fetch and data access; data wins, misaligned addresses fault without bus activity.
// Ports: clk, rst (sync, active-high); fetch port if_req/if_addr -> if_data/if_exc_code/if_ready;
// data port mem_req/mem_we/mem_addr/mem_wdata/mem_be -> mem_rdata/mem_exc_code/mem_ready;
// bus port bus_addr/bus_wdata/bus_be/bus_we/bus_oe, bus_rdata; stall to the pipeline.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int EXC_CODE_WIDTH = 5,
  parameter logic [EXC_CODE_WIDTH-1:0] EC_NONE = '0,
  parameter logic [EXC_CODE_WIDTH-1:0] EC_ADEL = EXC_CODE_WIDTH'(4),
  parameter logic [EXC_CODE_WIDTH-1:0] EC_ADES = EXC_CODE_WIDTH'(5)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  output logic [31:0]               if_data,
  output logic [EXC_CODE_WIDTH-1:0] if_exc_code,
  output logic                      if_ready,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_be,
  output logic [31:0]               mem_rdata,
  output logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
  output logic                      mem_ready,
  output logic [29:0]               bus_addr,
  output logic [31:0]               bus_wdata,
  output logic [3:0]                bus_be,
  output logic                      bus_we,
  output logic                      bus_oe,
  input  logic [31:0]               bus_rdata,
  output logic                      stall
);
  typedef enum logic [1:0] {IDLE, MEM_ACC, IF_ACC} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state;
  logic [3:0] cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] be_q;
  logic we_q;
  // A port whose ready is high this cycle has just been served and is skipped.
  logic sel_mem, sel_if, busy, done;
  logic [31:0] sel_addr;
  assign sel_mem = mem_req & ~mem_ready;
  assign sel_if = ~sel_mem & if_req & ~if_ready;
  assign sel_addr = sel_mem ? mem_addr : if_addr;
  assign busy = state != IDLE;
  assign done = busy && cnt == WC;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be = busy ? be_q : 4'h0;
  assign bus_we = busy & we_q;
  assign bus_oe = busy & ~we_q;
  assign stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      we_q <= 1'b0;
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      if_data <= '0;
      mem_rdata <= '0;
      if_exc_code <= EC_NONE;
      mem_exc_code <= EC_NONE;
    end else begin
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      if (!busy) begin
        if ((sel_mem | sel_if) && sel_addr[1:0] != 2'b00) begin
          if (sel_mem) begin
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            mem_exc_code <= mem_we ? EC_ADES : EC_ADEL;
          end else begin
            if_ready <= 1'b1;
            if_data <= '0;
            if_exc_code <= EC_ADEL;
          end
        end else if (sel_mem | sel_if) begin
          addr_q <= sel_addr[31:2];
          wdata_q <= sel_mem ? mem_wdata : wdata_q;
          be_q <= sel_mem ? mem_be : 4'hF;
          we_q <= sel_mem & mem_we;
          cnt <= '0;
          state <= sel_mem ? MEM_ACC : IF_ACC;
        end
      end else if (done) begin
        state <= IDLE;
        if (state == MEM_ACC) begin
          mem_ready <= 1'b1;
          mem_rdata <= we_q ? 32'h0 : bus_rdata;
          mem_exc_code <= EC_NONE;
        end else begin
          if_ready <= 1'b1;
          if_data <= bus_rdata;
          if_exc_code <= EC_NONE;
        end
      end else
        cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter at WAIT_CYCLES 1, 0 and 3.
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic if_req = 0, mem_req = 0, mem_we = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
  logic [3:0] mem_be = 0;
  logic [31:0] if_data, mem_rdata, bus_wdata;
  logic [4:0] if_exc, mem_exc;
  logic if_ready, mem_ready, bus_we, bus_oe, stall;
  logic [29:0] bus_addr;
  logic [3:0] bus_be;

  mem_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_exc_code(if_exc), .if_ready(if_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_exc_code(mem_exc), .mem_ready(mem_ready), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_we(bus_we), .bus_oe(bus_oe), .bus_rdata(bus_rdata), .stall(stall));

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  logic if_req0 = 0, if_req3 = 0;
  logic [31:0] if_addr0 = 0, if_addr3 = 0, if_data0, if_data3, mem_rdata0, mem_rdata3;
  logic [31:0] bus_wdata0, bus_wdata3;
  logic [4:0] if_exc0, if_exc3, mem_exc0, mem_exc3;
  logic if_ready0, if_ready3, mem_ready0, mem_ready3, bus_we0, bus_we3, bus_oe0, bus_oe3, stall0, stall3;
  logic [29:0] bus_addr0, bus_addr3;
  logic [3:0] bus_be0, bus_be3;

  mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .if_req(if_req0), .if_addr(if_addr0), .if_data(if_data0),
    .if_exc_code(if_exc0), .if_ready(if_ready0), .mem_req(1'b0), .mem_we(1'b0),
    .mem_addr(32'h0), .mem_wdata(32'h0), .mem_be(4'h0), .mem_rdata(mem_rdata0),
    .mem_exc_code(mem_exc0), .mem_ready(mem_ready0), .bus_addr(bus_addr0), .bus_wdata(bus_wdata0),
    .bus_be(bus_be0), .bus_we(bus_we0), .bus_oe(bus_oe0), .bus_rdata(model({bus_addr0, 2'b00})),
    .stall(stall0));

  mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .if_req(if_req3), .if_addr(if_addr3), .if_data(if_data3),
    .if_exc_code(if_exc3), .if_ready(if_ready3), .mem_req(1'b0), .mem_we(1'b0),
    .mem_addr(32'h0), .mem_wdata(32'h0), .mem_be(4'h0), .mem_rdata(mem_rdata3),
    .mem_exc_code(mem_exc3), .mem_ready(mem_ready3), .bus_addr(bus_addr3), .bus_wdata(bus_wdata3),
    .bus_be(bus_be3), .bus_we(bus_we3), .bus_oe(bus_oe3), .bus_rdata(model({bus_addr3, 2'b00})),
    .stall(stall3));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic is_mem; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic [31:0] rdata;
    int lat; logic [31:0] exp_data; logic [4:0] exp_exc; int exp_oe; int exp_we; logic [3:0] exp_be;
  } vec_t;
  vec_t v[7];

  initial begin
    int oe, we, lat, mr, ir;
    logic [3:0] cbe;
    logic [29:0] caddr;
    logic [31:0] cwd;
    logic any;
    int p0, p3, r0, r3;
    v[0] = '{0, 0, 32'h100, 0, 4'h0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 5'd0, 2, 0, 4'hF};
    v[1] = '{1, 0, 32'h204, 0, 4'hF, 32'h11223344, 3, 32'h11223344, 5'd0, 2, 0, 4'hF};
    v[2] = '{1, 1, 32'h200, 32'h12345678, 4'h3, 32'hFFFFFFFF, 3, 32'h0, 5'd0, 0, 2, 4'h3};
    v[3] = '{1, 0, 32'h203, 0, 4'hF, 32'hFFFFFFFF, 1, 32'h0, 5'd4, 0, 0, 4'h0};
    v[4] = '{1, 1, 32'h202, 32'hAAAA5555, 4'hF, 32'hFFFFFFFF, 1, 32'h0, 5'd5, 0, 0, 4'h0};
    v[5] = '{0, 0, 32'h102, 0, 4'h0, 32'hFFFFFFFF, 1, 32'h0, 5'd4, 0, 0, 4'h0};
    v[6] = '{0, 0, 32'h0, 0, 4'h0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 5'd0, 2, 0, 4'hF};

    tick();
    tick();
    chk("rst_if_ready", {31'b0, if_ready}, 0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 0);
    chk("rst_strobes", {29'b0, bus_we, bus_oe, stall}, 0);
    chk("rst_bus_be", {28'b0, bus_be}, 0);
    chk("rst_bus_addr", {2'b0, bus_addr}, 0);
    chk("rst_data", if_data | mem_rdata | bus_wdata, 0);
    chk("rst_exc", {22'b0, if_exc, mem_exc}, 0);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      if_req = !v[i].is_mem; mem_req = v[i].is_mem;
      if_addr = v[i].addr; mem_addr = v[i].addr; mem_we = v[i].we;
      mem_wdata = v[i].wdata; mem_be = v[i].be; bus_rdata = v[i].rdata;
      #1 chk($sformatf("v%0d_stall", i), {31'b0, stall}, 1);
      oe = 0; we = 0; lat = 0; cbe = 0; caddr = 0; cwd = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
        tick();
        if (bus_oe) oe++;
        if (bus_we) we++;
        if (bus_oe | bus_we) begin cbe = bus_be; caddr = bus_addr; cwd = bus_wdata; end
        if (v[i].is_mem ? mem_ready : if_ready) lat = n;
      end
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_data", i), v[i].is_mem ? mem_rdata : if_data, v[i].exp_data);
      chk($sformatf("v%0d_exc", i), {27'b0, v[i].is_mem ? mem_exc : if_exc}, {27'b0, v[i].exp_exc});
      chk($sformatf("v%0d_oe_cycles", i), oe, v[i].exp_oe);
      chk($sformatf("v%0d_we_cycles", i), we, v[i].exp_we);
      chk($sformatf("v%0d_be", i), {28'b0, cbe}, {28'b0, v[i].exp_be});
      if (v[i].exp_oe + v[i].exp_we > 0) chk($sformatf("v%0d_bus_addr", i), {2'b0, caddr}, v[i].addr >> 2);
      if (v[i].exp_we > 0) chk($sformatf("v%0d_bus_wdata", i), cwd, v[i].wdata);
      if (i == 1) chk("if_data_hold", if_data, 32'hDEADBEEF);
      if_req = 0; mem_req = 0;
      tick();
      chk($sformatf("v%0d_pulse", i), {30'b0, if_ready, mem_ready}, 0);
      chk($sformatf("v%0d_idle_strobe", i), {30'b0, bus_oe, bus_we}, 0);
    end

    if_req = 1; if_addr = 0; bus_rdata = 32'h0BADF00D;
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'h12345678; mem_be = 4'h3;
    mr = 0; ir = 0; oe = 0; we = 0; cbe = 0;
    for (int n = 1; n <= 12 && ir == 0; n++) begin
      tick();
      if (bus_oe) oe++;
      if (bus_we) begin we++; cbe = bus_be; end
      if (mem_ready && mr == 0) begin mr = n; mem_req = 0; end
      if (if_ready && ir == 0) begin ir = n; if_req = 0; end
    end
    chk("sim_mem_ready_cycle", mr, 3);
    chk("sim_if_ready_cycle", ir, 6);
    chk("sim_we_cycles", we, 2);
    chk("sim_oe_cycles", oe, 2);
    chk("sim_we_be", {28'b0, cbe}, 4'h3);
    chk("sim_if_data", if_data, 32'h0BADF00D);
    tick();

    mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_be = 4'hF; bus_rdata = 32'h77665544;
    tick();
    mem_req = 0;
    lat = 0;
    for (int n = 2; n <= 12 && lat == 0; n++) begin
      tick();
      if (mem_ready) lat = n;
    end
    chk("drop_latency", lat, 3);
    chk("drop_data", mem_rdata, 32'h77665544);
    tick();

    if_req = 1; if_addr = 32'h100; bus_rdata = 32'hDEADBEEF;
    tick();
    tick();
    chk("pre_rst_oe", {31'b0, bus_oe}, 1);
    rst = 1; if_req = 0;
    tick();
    chk("mid_rst_strobes", {29'b0, bus_oe, bus_we, if_ready}, 0);
    chk("mid_rst_be", {28'b0, bus_be}, 0);
    chk("mid_rst_bus", {2'b0, bus_addr} | bus_wdata, 0);
    chk("mid_rst_data", if_data | mem_rdata, 0);
    chk("mid_rst_exc", {22'b0, if_exc, mem_exc}, 0);
    rst = 0;
    any = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      any |= if_ready | bus_oe;
    end
    chk("post_rst_quiet", {31'b0, any}, 0);

    if_addr0 = 32'h1000; if_addr3 = 32'h2000; if_req0 = 1; if_req3 = 1;
    p0 = -1; p3 = -1; r0 = 0; r3 = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (if_ready0) begin
        chk($sformatf("w0_interval%0d", r0), c - p0, 3);
        chk($sformatf("w0_data%0d", r0), if_data0, model(if_addr0));
        if_addr0 += 4; p0 = c; r0++;
      end
      if (if_ready3) begin
        chk($sformatf("w3_interval%0d", r3), c - p3, 6);
        chk($sformatf("w3_data%0d", r3), if_data3, model(if_addr3));
        if_addr3 += 4; p3 = c; r3++;
      end
    end
    chk("w0_count", r0, 13);
    chk("w3_count", r3, 6);
    if_req0 = 0; if_req3 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
